// File: rtl/apb_ddr_cfg_pkg.sv
// Shared constants for the DDR controller configuration slave: register
// offsets, training bit positions and interrupt-enable layout.
`timescale 1ns/1ps
package apb_ddr_cfg_pkg;

  localparam logic [7:0] ADDR_MRW_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_MRR_CTRL   = 8'h04;
  localparam logic [7:0] ADDR_PPR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_RANK_STAT  = 8'h0C;
  localparam logic [7:0] ADDR_TRAIN_CTRL = 8'h10;
  localparam logic [7:0] ADDR_TRAIN_STAT = 8'h14;
  localparam logic [7:0] ADDR_IRQ_EN     = 8'h18;
  localparam logic [7:0] ADDR_PPR_STAT   = 8'h1C;

  // TRAIN_CTRL / TRAIN_STAT bit positions
  localparam int TRN_CA      = 0;
  localparam int TRN_WR_DQ   = 1;
  localparam int TRN_WR_LVL  = 2;
  localparam int TRN_RD_LVL  = 3;
  localparam int TRN_RD_GATE = 4;
  localparam int TRN_ZQ      = 5;
  localparam int TRN_ALL     = 6;
  localparam int NB_TRAIN    = 7;

  localparam int IRQ_MRW   = 0;
  localparam int IRQ_MRR   = 1;
  localparam int IRQ_PPR   = 2;
  localparam int IRQ_TRAIN = 3;
  localparam logic [3:0] IRQ_EN_RST = 4'hF;

  typedef enum logic [3:0] {
    REG_NONE,
    REG_MRW_CTRL,
    REG_MRR_CTRL,
    REG_PPR_CTRL,
    REG_RANK_STAT,
    REG_TRAIN_CTRL,
    REG_TRAIN_STAT,
    REG_IRQ_EN,
    REG_PPR_STAT
  } reg_sel_e;

endpackage

// File: rtl/apb_ddr_cfg_selfclr_bit.sv
// Request/done/sticky cell: a request bit that self-clears on its done input
// and logs the completion in a write-one-to-clear sticky bit.
`timescale 1ns/1ps
module apb_ddr_cfg_selfclr_bit #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ctrl_we,
  input  logic [W-1:0] i_ctrl_wdata,
  input  logic         i_stat_we,
  input  logic [W-1:0] i_stat_wdata,
  input  logic [W-1:0] i_done,
  output logic [W-1:0] o_ctrl,
  output logic [W-1:0] o_sticky
);

  logic [W-1:0] r_ctrl;
  logic [W-1:0] r_sticky;
  logic [W-1:0] w_done_evt;
  logic [W-1:0] w_w1c;

  // A done only counts while its request is pending.
  assign w_done_evt = r_ctrl & i_done;
  assign w_w1c      = i_stat_we ? i_stat_wdata : '0;

  // NOTE: state is updated with <= so every bit samples the pre-edge values of
  // r_ctrl and i_done; blocking assignments here would race the sticky update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl   <= '0;
      r_sticky <= '0;
    end else begin
      r_ctrl   <= i_ctrl_we ? i_ctrl_wdata : (r_ctrl & ~i_done);
      r_sticky <= (r_sticky & ~w_w1c) | w_done_evt;
    end
  end

  assign o_ctrl   = r_ctrl;
  assign o_sticky = r_sticky;

endmodule

// File: rtl/apb_ddr_cfg_slave.sv
// APB4 completer for DDR MC/PHY configuration: per-rank MRW/MRR/PPR requests,
// PHY training starts, W1C done status and a maskable level interrupt.
`timescale 1ns/1ps
module apb_ddr_cfg_slave
  import apb_ddr_cfg_pkg::*;
#(
  parameter int APB_ADDRWIDTH = 16,
  parameter int APB_DATAWIDTH = 8,
  parameter int NB_RANK       = 2
) (
  input  logic                     pclk_i,
  input  logic                     prst_ni,
  input  logic [APB_ADDRWIDTH-1:0] paddr_i,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pwrite_i,
  input  logic [APB_DATAWIDTH-1:0] pwdata_i,
  input  logic [3:0]               pstrb_i,
  output logic                     pready_o,
  output logic [APB_DATAWIDTH-1:0] prdata_o,
  output logic                     pslverr_o,
  input  logic [NB_RANK-1:0]       mrw_done_status_i,
  input  logic [NB_RANK-1:0]       mrr_done_status_i,
  input  logic [NB_RANK-1:0]       ppr_done_status_i,
  input  logic [NB_RANK-1:0]       ppr_status_i,
  output logic [NB_RANK-1:0]       rank_mrw_o,
  output logic [NB_RANK-1:0]       rank_mrr_o,
  output logic [NB_RANK-1:0]       ppr_en_o,
  output logic                     ca_training_start_o,
  output logic                     wr_dq_training_start_o,
  output logic                     wr_lvl_training_start_o,
  output logic                     rd_lvl_training_start_o,
  output logic                     rd_gate_training_start_o,
  output logic                     zq_training_start_o,
  output logic                     all_training_start_o,
  input  logic                     ca_training_done_i,
  input  logic                     wr_dq_training_done_i,
  input  logic                     wr_lvl_training_done_i,
  input  logic                     rd_lvl_training_done_i,
  input  logic                     rd_gate_training_done_i,
  input  logic                     zq_training_done_i,
  input  logic                     all_training_done_i,
  output logic                     mc_intr_o
);

  reg_sel_e                 w_sel;
  logic                     w_err;
  logic                     w_wr_en;
  logic [APB_DATAWIDTH-1:0] w_rdata;
  logic [NB_RANK-1:0]       w_mrw_st, w_mrr_st, w_ppr_st;
  logic [NB_TRAIN-1:0]      w_train_start, w_train_st, w_train_done;
  logic [3:0]               r_irq_en;
  logic                     r_mc_intr;
  logic                     w_unused;

  // Strobes are ignored and high data bits beyond the register fields are don't-care.
  assign w_unused = ^{pstrb_i, pwdata_i};

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_sel = REG_NONE;
    case (paddr_i)
      APB_ADDRWIDTH'(ADDR_MRW_CTRL):   w_sel = REG_MRW_CTRL;
      APB_ADDRWIDTH'(ADDR_MRR_CTRL):   w_sel = REG_MRR_CTRL;
      APB_ADDRWIDTH'(ADDR_PPR_CTRL):   w_sel = REG_PPR_CTRL;
      APB_ADDRWIDTH'(ADDR_RANK_STAT):  w_sel = REG_RANK_STAT;
      APB_ADDRWIDTH'(ADDR_TRAIN_CTRL): w_sel = REG_TRAIN_CTRL;
      APB_ADDRWIDTH'(ADDR_TRAIN_STAT): w_sel = REG_TRAIN_STAT;
      APB_ADDRWIDTH'(ADDR_IRQ_EN):     w_sel = REG_IRQ_EN;
      APB_ADDRWIDTH'(ADDR_PPR_STAT):   w_sel = REG_PPR_STAT;
      default:                         w_sel = REG_NONE;
    endcase
  end

  // Only unmapped addresses error; the RO half of PPR_STAT silently drops writes.
  assign w_err     = (w_sel == REG_NONE);
  assign w_wr_en   = psel_i & penable_i & pwrite_i & ~w_err;
  assign pslverr_o = psel_i & penable_i & w_err;
  assign pready_o  = 1'b1;

  apb_ddr_cfg_selfclr_bit #(.W(NB_RANK)) u_mrw (
    .clk          (pclk_i),
    .rst_n        (prst_ni),
    .i_ctrl_we    (w_wr_en && (w_sel == REG_MRW_CTRL)),
    .i_ctrl_wdata (pwdata_i[NB_RANK-1:0]),
    .i_stat_we    (w_wr_en && (w_sel == REG_RANK_STAT)),
    .i_stat_wdata (pwdata_i[NB_RANK-1:0]),
    .i_done       (mrw_done_status_i),
    .o_ctrl       (rank_mrw_o),
    .o_sticky     (w_mrw_st)
  );

  apb_ddr_cfg_selfclr_bit #(.W(NB_RANK)) u_mrr (
    .clk          (pclk_i),
    .rst_n        (prst_ni),
    .i_ctrl_we    (w_wr_en && (w_sel == REG_MRR_CTRL)),
    .i_ctrl_wdata (pwdata_i[NB_RANK-1:0]),
    .i_stat_we    (w_wr_en && (w_sel == REG_RANK_STAT)),
    .i_stat_wdata (pwdata_i[4 +: NB_RANK]),
    .i_done       (mrr_done_status_i),
    .o_ctrl       (rank_mrr_o),
    .o_sticky     (w_mrr_st)
  );

  apb_ddr_cfg_selfclr_bit #(.W(NB_RANK)) u_ppr (
    .clk          (pclk_i),
    .rst_n        (prst_ni),
    .i_ctrl_we    (w_wr_en && (w_sel == REG_PPR_CTRL)),
    .i_ctrl_wdata (pwdata_i[NB_RANK-1:0]),
    .i_stat_we    (w_wr_en && (w_sel == REG_PPR_STAT)),
    .i_stat_wdata (pwdata_i[NB_RANK-1:0]),
    .i_done       (ppr_done_status_i),
    .o_ctrl       (ppr_en_o),
    .o_sticky     (w_ppr_st)
  );

  assign w_train_done = {all_training_done_i, zq_training_done_i, rd_gate_training_done_i,
                         rd_lvl_training_done_i, wr_lvl_training_done_i,
                         wr_dq_training_done_i, ca_training_done_i};

  apb_ddr_cfg_selfclr_bit #(.W(NB_TRAIN)) u_train (
    .clk          (pclk_i),
    .rst_n        (prst_ni),
    .i_ctrl_we    (w_wr_en && (w_sel == REG_TRAIN_CTRL)),
    .i_ctrl_wdata (pwdata_i[NB_TRAIN-1:0]),
    .i_stat_we    (w_wr_en && (w_sel == REG_TRAIN_STAT)),
    .i_stat_wdata (pwdata_i[NB_TRAIN-1:0]),
    .i_done       (w_train_done),
    .o_ctrl       (w_train_start),
    .o_sticky     (w_train_st)
  );

  assign ca_training_start_o      = w_train_start[TRN_CA];
  assign wr_dq_training_start_o   = w_train_start[TRN_WR_DQ];
  assign wr_lvl_training_start_o  = w_train_start[TRN_WR_LVL];
  assign rd_lvl_training_start_o  = w_train_start[TRN_RD_LVL];
  assign rd_gate_training_start_o = w_train_start[TRN_RD_GATE];
  assign zq_training_start_o      = w_train_start[TRN_ZQ];
  assign all_training_start_o     = w_train_start[TRN_ALL];

  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      r_irq_en  <= IRQ_EN_RST;
      r_mc_intr <= 1'b0;
    end else begin
      if (w_wr_en && (w_sel == REG_IRQ_EN)) r_irq_en <= pwdata_i[3:0];
      r_mc_intr <= (|w_mrw_st   & r_irq_en[IRQ_MRW])
                 | (|w_mrr_st   & r_irq_en[IRQ_MRR])
                 | (|w_ppr_st   & r_irq_en[IRQ_PPR])
                 | (|w_train_st & r_irq_en[IRQ_TRAIN]);
    end
  end

  assign mc_intr_o = r_mc_intr;

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_MRW_CTRL:   w_rdata[NB_RANK-1:0]  = rank_mrw_o;
      REG_MRR_CTRL:   w_rdata[NB_RANK-1:0]  = rank_mrr_o;
      REG_PPR_CTRL:   w_rdata[NB_RANK-1:0]  = ppr_en_o;
      REG_RANK_STAT: begin
        w_rdata[NB_RANK-1:0] = w_mrw_st;
        w_rdata[4 +: NB_RANK] = w_mrr_st;
      end
      REG_TRAIN_CTRL: w_rdata[NB_TRAIN-1:0] = w_train_start;
      REG_TRAIN_STAT: w_rdata[NB_TRAIN-1:0] = w_train_st;
      REG_IRQ_EN:     w_rdata[3:0]          = r_irq_en;
      REG_PPR_STAT: begin
        w_rdata[NB_RANK-1:0] = w_ppr_st;
        w_rdata[4 +: NB_RANK] = ppr_status_i;
      end
      default:        w_rdata = '0;
    endcase
  end

  assign prdata_o = (psel_i && !pwrite_i) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_ddr_cfg_slave.sv
// Directed bench for apb_ddr_cfg_slave: APB access, self-clear, W1C,
// interrupt masking, error response and asynchronous reset.
`timescale 1ns/1ps
module tb_apb_ddr_cfg_slave;

  logic        pclk_i = 1'b0;
  logic        prst_ni;
  logic [15:0] paddr_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [7:0]  pwdata_i;
  logic [3:0]  pstrb_i;
  logic        pready_o;
  logic [7:0]  prdata_o;
  logic        pslverr_o;
  logic [1:0]  mrw_done, mrr_done, ppr_done, ppr_status;
  logic [1:0]  rank_mrw_o, rank_mrr_o, ppr_en_o;
  logic [6:0]  tdone;
  logic [6:0]  starts;
  logic        mc_intr_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk_i = ~pclk_i;

  apb_ddr_cfg_slave dut (
    .pclk_i                   (pclk_i),
    .prst_ni                  (prst_ni),
    .paddr_i                  (paddr_i),
    .psel_i                   (psel_i),
    .penable_i                (penable_i),
    .pwrite_i                 (pwrite_i),
    .pwdata_i                 (pwdata_i),
    .pstrb_i                  (pstrb_i),
    .pready_o                 (pready_o),
    .prdata_o                 (prdata_o),
    .pslverr_o                (pslverr_o),
    .mrw_done_status_i        (mrw_done),
    .mrr_done_status_i        (mrr_done),
    .ppr_done_status_i        (ppr_done),
    .ppr_status_i             (ppr_status),
    .rank_mrw_o               (rank_mrw_o),
    .rank_mrr_o               (rank_mrr_o),
    .ppr_en_o                 (ppr_en_o),
    .ca_training_start_o      (starts[0]),
    .wr_dq_training_start_o   (starts[1]),
    .wr_lvl_training_start_o  (starts[2]),
    .rd_lvl_training_start_o  (starts[3]),
    .rd_gate_training_start_o (starts[4]),
    .zq_training_start_o      (starts[5]),
    .all_training_start_o     (starts[6]),
    .ca_training_done_i       (tdone[0]),
    .wr_dq_training_done_i    (tdone[1]),
    .wr_lvl_training_done_i   (tdone[2]),
    .rd_lvl_training_done_i   (tdone[3]),
    .rd_gate_training_done_i  (tdone[4]),
    .zq_training_done_i       (tdone[5]),
    .all_training_done_i      (tdone[6]),
    .mc_intr_o                (mc_intr_o)
  );

  task automatic tick();
    @(posedge pclk_i); #1;
  endtask

  // Training done vector td is held only across the commit edge of the access.
  task automatic apb_write(input logic [15:0] addr, input logic [7:0] data,
                           input logic [6:0] td, output logic err);
    @(posedge pclk_i); #1;
    psel_i = 1'b1; pwrite_i = 1'b1; penable_i = 1'b0; paddr_i = addr; pwdata_i = data;
    @(posedge pclk_i); #1;
    penable_i = 1'b1; tdone = td;
    #1 err = pslverr_o;
    @(posedge pclk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; tdone = 7'h00;
  endtask

  task automatic apb_read(input logic [15:0] addr, output logic [7:0] data, output logic err);
    @(posedge pclk_i); #1;
    psel_i = 1'b1; pwrite_i = 1'b0; penable_i = 1'b0; paddr_i = addr;
    @(posedge pclk_i); #1;
    penable_i = 1'b1;
    #1 begin data = prdata_o; err = pslverr_o; end
    @(posedge pclk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd; logic err;
    n_tests++; if (pready_o !== 1'b1) begin n_fail++; $display("FAIL rst_pready: got %b want 1", pready_o); end
    n_tests++; if ({starts, rank_mrw_o, rank_mrr_o, ppr_en_o, mc_intr_o} !== 14'h0) begin
      n_fail++; $display("FAIL rst_outputs: got %h want 0", {starts, rank_mrw_o, rank_mrr_o, ppr_en_o, mc_intr_o}); end
    n_tests++; if (prdata_o !== 8'h00) begin n_fail++; $display("FAIL rst_prdata_idle: got %h want 00", prdata_o); end
    apb_read(16'h0018, rd, err);
    n_tests++; if (rd !== 8'h0F) begin n_fail++; $display("FAIL rst_irq_en: got %h want 0f", rd); end
    apb_read(16'h0014, rd, err);
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rst_train_stat: got %h want 00", rd); end
  endtask

  task automatic test_training();
    logic [7:0] rd; logic err;
    apb_write(16'h0010, 8'h20, 7'h00, err);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL t1_wr_err: got %b want 0", err); end
    n_tests++; if (starts !== 7'h20) begin n_fail++; $display("FAIL t1_zq_start: got %h want 20", starts); end
    tdone = 7'h20; tick(); tdone = 7'h00;
    n_tests++; if (starts !== 7'h00) begin n_fail++; $display("FAIL t1_zq_selfclr: got %h want 00", starts); end
    n_tests++; if (mc_intr_o !== 1'b0) begin n_fail++; $display("FAIL t1_intr_lag: got %b want 0", mc_intr_o); end
    tick();
    n_tests++; if (mc_intr_o !== 1'b1) begin n_fail++; $display("FAIL t1_intr: got %b want 1", mc_intr_o); end
    apb_read(16'h0014, rd, err);
    n_tests++; if (rd !== 8'h20) begin n_fail++; $display("FAIL t1_train_stat: got %h want 20", rd); end
    apb_write(16'h0014, 8'h20, 7'h00, err);
    apb_read(16'h0014, rd, err);
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL t1_w1c: got %h want 00", rd); end
    n_tests++; if (mc_intr_o !== 1'b0) begin n_fail++; $display("FAIL t1_intr_clr: got %b want 0", mc_intr_o); end
  endtask

  task automatic test_mrw();
    logic [7:0] rd; logic err;
    apb_write(16'h0000, 8'h03, 7'h00, err);
    n_tests++; if (rank_mrw_o !== 2'b11) begin n_fail++; $display("FAIL t2_mrw_set: got %b want 11", rank_mrw_o); end
    mrw_done = 2'b01; tick(); mrw_done = 2'b00;
    n_tests++; if (rank_mrw_o !== 2'b10) begin n_fail++; $display("FAIL t2_mrw_selfclr: got %b want 10", rank_mrw_o); end
    apb_read(16'h000C, rd, err);
    n_tests++; if (rd !== 8'h01) begin n_fail++; $display("FAIL t2_rank_stat: got %h want 01", rd); end
    n_tests++; if (mc_intr_o !== 1'b1) begin n_fail++; $display("FAIL t2_intr: got %b want 1", mc_intr_o); end
    apb_write(16'h000C, 8'h01, 7'h00, err);
    apb_read(16'h000C, rd, err);
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL t2_w1c: got %h want 00", rd); end
    n_tests++; if (mc_intr_o !== 1'b0) begin n_fail++; $display("FAIL t2_intr_clr: got %b want 0", mc_intr_o); end
    // Abort rank1 by writing 0: no status may be logged.
    apb_write(16'h0000, 8'h00, 7'h00, err);
    n_tests++; if (rank_mrw_o !== 2'b00) begin n_fail++; $display("FAIL t2_abort: got %b want 00", rank_mrw_o); end
    mrw_done = 2'b10; tick(); mrw_done = 2'b00;
    apb_read(16'h000C, rd, err);
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL t2_done_idle: got %h want 00", rd); end
  endtask

  task automatic test_irq_mask();
    logic [7:0] rd; logic err;
    apb_write(16'h0018, 8'h00, 7'h00, err);
    apb_write(16'h0004, 8'h02, 7'h00, err);
    n_tests++; if (rank_mrr_o !== 2'b10) begin n_fail++; $display("FAIL t3_mrr_set: got %b want 10", rank_mrr_o); end
    mrr_done = 2'b11; tick(); mrr_done = 2'b00;
    n_tests++; if (rank_mrr_o !== 2'b00) begin n_fail++; $display("FAIL t3_mrr_selfclr: got %b want 00", rank_mrr_o); end
    apb_read(16'h000C, rd, err);
    n_tests++; if (rd !== 8'h20) begin n_fail++; $display("FAIL t3_rank_stat: got %h want 20", rd); end
    tick();
    n_tests++; if (mc_intr_o !== 1'b0) begin n_fail++; $display("FAIL t3_intr_masked: got %b want 0", mc_intr_o); end
    apb_write(16'h0018, 8'h02, 7'h00, err);
    tick();
    n_tests++; if (mc_intr_o !== 1'b1) begin n_fail++; $display("FAIL t3_intr_unmask: got %b want 1", mc_intr_o); end
    apb_write(16'h000C, 8'h20, 7'h00, err);
    apb_write(16'h0018, 8'h0F, 7'h00, err);
    tick();
    n_tests++; if (mc_intr_o !== 1'b0) begin n_fail++; $display("FAIL t3_intr_clr: got %b want 0", mc_intr_o); end
  endtask

  task automatic test_err_ppr();
    logic [7:0] rd; logic err;
    apb_read(16'h0040, rd, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL t4_rd_err: got %b want 1", err); end
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL t4_rd_data: got %h want 00", rd); end
    apb_read(16'h0100, rd, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL t4_full_decode: got %b want 1", err); end
    apb_write(16'h0108, 8'h01, 7'h00, err);
    n_tests++; if (err !== 1'b1 || ppr_en_o !== 2'b00) begin
      n_fail++; $display("FAIL t4_wr_err: got err=%b ppr=%b want err=1 ppr=00", err, ppr_en_o); end
    apb_write(16'h0008, 8'h01, 7'h00, err);
    n_tests++; if (ppr_en_o !== 2'b01) begin n_fail++; $display("FAIL t4_ppr_set: got %b want 01", ppr_en_o); end
    ppr_done = 2'b01; tick(); ppr_done = 2'b00;
    apb_read(16'h001C, rd, err);
    n_tests++; if (rd !== 8'h01 || ppr_en_o !== 2'b00) begin
      n_fail++; $display("FAIL t4_ppr_stat: got stat=%h en=%b want 01/00", rd, ppr_en_o); end
    apb_write(16'h001C, 8'hFF, 7'h00, err);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL t4_ro_wr_err: got %b want 0", err); end
    apb_read(16'h001C, rd, err);
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL t4_ppr_w1c: got %h want 00", rd); end
    ppr_status = 2'b10;
    apb_read(16'h001C, rd, err);
    n_tests++; if (rd !== 8'h20) begin n_fail++; $display("FAIL t4_ppr_live: got %h want 20", rd); end
    ppr_status = 2'b00;
  endtask

  task automatic test_async_reset();
    logic [7:0] rd; logic err;
    apb_write(16'h0000, 8'h03, 7'h00, err);
    apb_write(16'h0018, 8'h05, 7'h00, err);
    apb_write(16'h0010, 8'h7F, 7'h00, err);
    n_tests++; if (starts !== 7'h7F) begin n_fail++; $display("FAIL t5_all_start: got %h want 7f", starts); end
    #2 prst_ni = 1'b0;
    #1;
    n_tests++; if (starts !== 7'h00 || rank_mrw_o !== 2'b00) begin
      n_fail++; $display("FAIL t5_async_rst: got starts=%h mrw=%b want 00/00", starts, rank_mrw_o); end
    #15 prst_ni = 1'b1;
    apb_read(16'h0018, rd, err);
    n_tests++; if (rd !== 8'h0F) begin n_fail++; $display("FAIL t5_irq_en_rst: got %h want 0f", rd); end
    apb_read(16'h0010, rd, err);
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL t5_train_ctrl_rst: got %h want 00", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic err;
    apb_write(16'h0010, 8'h01, 7'h00, err);
    // W1C of bit0 collides with ca done: the set must win.
    apb_write(16'h0014, 8'h01, 7'h01, err);
    n_tests++; if (starts !== 7'h00) begin n_fail++; $display("FAIL t6_ca_selfclr: got %h want 00", starts); end
    apb_read(16'h0014, rd, err);
    n_tests++; if (rd !== 8'h01) begin n_fail++; $display("FAIL t6_set_wins: got %h want 01", rd); end
    apb_write(16'h0010, 8'h02, 7'h00, err);
    // Control write collides with wr_dq done: write wins, status still logged.
    apb_write(16'h0010, 8'h02, 7'h02, err);
    n_tests++; if (starts !== 7'h02) begin n_fail++; $display("FAIL t6_write_wins: got %h want 02", starts); end
    apb_read(16'h0014, rd, err);
    n_tests++; if (rd !== 8'h03) begin n_fail++; $display("FAIL t6_stat_logged: got %h want 03", rd); end
  endtask

  initial begin
    prst_ni = 1'b0; paddr_i = '0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    pwdata_i = '0; pstrb_i = 4'hF; mrw_done = '0; mrr_done = '0; ppr_done = '0;
    ppr_status = '0; tdone = '0;
    #23 prst_ni = 1'b1;
    tick();
    test_reset();
    test_training();
    test_mrw();
    test_irq_mask();
    test_err_ppr();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_ddr_cfg_slave.md
Name: apb_ddr_cfg_slave

Overview:
- APB4 completer (slave) holding the DDR memory-controller configuration/command registers: per-rank MRW/MRR triggers, per-rank PPR enable, and seven PHY training start bits.
- Start/trigger bits self-clear when the matching done input returns; done events are logged in W1C status registers and raise a maskable interrupt.
- Sits between the APB interconnect and the MC/PHY training sequencers.

Parameters:
- APB_ADDRWIDTH, 16, width of paddr_i.
- APB_DATAWIDTH, 8, width of pwdata_i/prdata_o; all registers are 8 bits.
- NB_RANK, 2, number of DRAM ranks; legal range 1..4.

Ports:
- pclk_i in 1: APB clock, the only clock.
- prst_ni in 1: asynchronous active-low reset.
- paddr_i in APB_ADDRWIDTH: byte address.
- psel_i, penable_i, pwrite_i in 1 each: APB control.
- pwdata_i in APB_DATAWIDTH: write data.
- pstrb_i in 4: write strobe; ignored, every write updates the full byte.
- pready_o out 1; prdata_o out APB_DATAWIDTH; pslverr_o out 1.
- mrw_done_status_i, mrr_done_status_i, ppr_done_status_i, ppr_status_i in NB_RANK each: per-rank done/status levels.
- rank_mrw_o, rank_mrr_o, ppr_en_o out NB_RANK each: per-rank requests.
- ca_, wr_dq_, wr_lvl_, rd_lvl_, rd_gate_, zq_, all_training_start_o out 1 each.
- matching *_training_done_i in 1 each.
- mc_intr_o out 1: level interrupt.

Behaviour:
APB protocol:
- No wait states: pready_o is tied to 1.
- A write commits on the rising edge where psel_i&penable_i&pwrite_i.
- prdata_o is combinational from paddr_i while psel_i&!pwrite_i; it is 0 otherwise.
- pslverr_o=1 during the access phase for an unmapped address, or a write to a RO register. A write that errors changes no state.
- Address decode uses the full paddr_i.

Register map (unused bits read 0, ignore writes):
- 0x00 MRW_CTRL RW: [NB_RANK-1:0] drives rank_mrw_o.
- 0x04 MRR_CTRL RW: [NB_RANK-1:0] drives rank_mrr_o.
- 0x08 PPR_CTRL RW: [NB_RANK-1:0] drives ppr_en_o.
- 0x0C RANK_STAT W1C: [NB_RANK-1:0] MRW done sticky; [4+NB_RANK-1:4] MRR done sticky.
- 0x10 TRAIN_CTRL RW, one start bit per training:
  - bit0 ca, bit1 wr_dq, bit2 wr_lvl, bit3 rd_lvl, bit4 rd_gate, bit5 zq, bit6 all.
  - Each bit drives its *_training_start_o directly (registered, level).
- 0x14 TRAIN_STAT W1C: bits 0..6 are done sticky, same bit order as TRAIN_CTRL.
- 0x18 IRQ_EN RW, reset 0x0F: bit0 MRW, bit1 MRR, bit2 PPR, bit3 training.
- 0x1C PPR_STAT: [NB_RANK-1:0] PPR done sticky (W1C); [4+NB_RANK-1:4] live ppr_status_i (RO, writes ignored without error).

Self-clear rule (applies per bit to MRW, MRR, PPR enable and each training start):
- If the control bit is 1 and its done input is 1 at a rising edge, the control bit clears and the sticky status bit sets.
- Clear and set occur on the same edge. The start output drops one cycle after done is sampled.
- A done input while the control bit is 0 is ignored.
- A same-cycle APB write to the control register wins over self-clear; the status bit is still set.
- Writing 0 to a set control bit aborts the request and sets no status.
- W1C: write 1 clears a sticky bit. If a set event occurs in the same cycle, the set wins.

Interrupt and reset:
- mc_intr_o is registered:
  - (|MRW sticky & en0) | (|MRR sticky & en1) | (|PPR sticky & en2) | (|TRAIN_STAT & en3).
- Reset: every register is 0 except IRQ_EN=0x0F.
- All outputs are 0 at reset, except pready_o=1.
- Reset mid-request drops all start/request outputs immediately (asynchronous).

Decomposition:
- Package apb_ddr_cfg_pkg holds:
  - register offset localparams;
  - TRAIN_CTRL bit-index constants;
  - IRQ_EN bit indices and reset value.
- One sub-module, apb_ddr_cfg_selfclr_bit: a parameterised-width request/done/sticky cell. It is instantiated for MRW, MRR, PPR and the training vector.

Test Plan:
1. Write 0x10=0x20 -> zq_training_start_o=1 the cycle after the access; all other starts 0. Raise zq_training_done_i -> start drops next edge. Read 0x14 returns 0x20; mc_intr_o=1.
2. Write 0x00=0x03 -> rank_mrw_o=2'b11. Pulse mrw_done_status_i=2'b01 -> rank_mrw_o=2'b10. Read 0x0C returns 0x01. Write 0x0C=0x01 -> reads 0x00 and mc_intr_o=0.
3. Write 0x18=0x00, then complete an MRR on rank1 -> 0x0C reads 0x20 but mc_intr_o stays 0. Write 0x18=0x02 -> mc_intr_o=1.
4. Read 0x40 -> pslverr_o=1 and prdata_o=0. Write 0x1C=0xFF -> no error; PPR done stickies clear. ppr_status_i=2'b10 -> 0x1C reads 0x20.
5. Write 0x10=0x7F, then assert prst_ni=0 mid-request -> all start outputs 0 immediately. After reset, IRQ_EN reads 0x0F.
6. Same-cycle TRAIN_STAT W1C write and ca_training_done_i with ca start set -> TRAIN_STAT bit0 reads 1.
